triumph_icache: RTL
===================

Name: triumph_icache

Overview:
- Direct-mapped, read-only instruction cache; the responder side of the IF-stage fetch interface.
- Accepts word-addressed fetch requests from the IF stage and returns 32-bit instructions.
- On a miss, refills a whole line from backing instruction memory over a req/gnt/rvalid bus.
- Sits between the IF stage and the instruction memory. Provides hit/miss counters for bring-up.

Parameters:
- LINE_WORDS, 4: words per line. Power of 2, ≥2.
- NUM_LINES, 16: number of lines. Power of 2, ≥2.
- ADDR_W, 32: width of the word address.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- req_i  in  1  fetch request from IF.
- addr_i  in  ADDR_W  fetch word address (PC increments by 1 per instruction).
- ready_o  out  1  cache can accept a request this cycle.
- rvalid_o  out  1  rdata_o valid, one-cycle pulse per accepted request.
- rdata_o  out  32  fetched instruction.
- flush_i  in  1  invalidate all lines.
- mem_req_o  out  1  backing-memory read request.
- mem_addr_o  out  ADDR_W  backing-memory word address.
- mem_gnt_i  in  1  request accepted by memory.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  read data.
- hit_cnt_o  out  32  saturating hit counter.
- miss_cnt_o  out  32  saturating miss counter.

Behaviour:
- Address split (OFF=log2 LINE_WORDS, IDX=log2 NUM_LINES):
  - offset = addr[OFF-1:0]
  - index = addr[OFF+IDX-1:OFF]
  - tag = remaining upper bits
- Storage: data array, tag array, and one valid bit per line. Only the valid bits are reset.
- Reset (rst_ni=0 at a clock edge):
  - All valid bits cleared; state=IDLE.
  - ready_o=0, rvalid_o=0, rdata_o=0, mem_req_o=0, mem_addr_o=0, hit_cnt_o=0, miss_cnt_o=0.
  - Reset mid-refill aborts the refill. Any later mem_rvalid_i is ignored until a new request is issued.
- States: IDLE, REFILL_REQ, REFILL_WAIT, RESP.
- IDLE:
  - ready_o=1. A request is accepted when req_i && ready_o.
  - Hit (valid && tag match): next cycle rvalid_o=1 and rdata_o=data[index][offset]; state stays IDLE. Back-to-back hits give one response per cycle.
  - Miss: the request is latched and the line base is set to addr with offset bits zeroed; word counter=0; go to REFILL_REQ. No rvalid_o follows the miss cycle.
- REFILL_REQ:
  - ready_o=0, mem_req_o=1, mem_addr_o=line base + word counter.
  - mem_req_o and mem_addr_o are held stable until mem_gnt_i=1, then go to REFILL_WAIT.
  - mem_req_o is deasserted in REFILL_WAIT. There is one outstanding read at a time.
- REFILL_WAIT:
  - On mem_rvalid_i, write mem_rdata_i into data[index][counter].
  - If counter == LINE_WORDS-1: write the tag, set valid (unless a flush is pending), go to RESP.
  - Otherwise increment the counter and return to REFILL_REQ.
  - mem_rvalid_i in any other state is ignored.
- RESP:
  - rvalid_o=1 with rdata_o = refilled word at the latched offset; ready_o=0; next state IDLE.
  - Miss latency: response cycle = cycle after the last mem_rvalid_i.
- rvalid_o is low in every cycle not listed above. rdata_o holds its last value when rvalid_o=0.
- Flush:
  - In IDLE, flush_i clears all valid bits at the edge. A request accepted in the same cycle as flush_i is treated as a miss.
  - During a refill, flush_i sets a pending flag. The refill completes and RESP still returns the data, but the line is not marked valid, and all valid bits are cleared at refill end. The flag is cleared entering IDLE.
- Counters:
  - hit_cnt_o increments on each accepted hit; miss_cnt_o on each accepted miss.
  - Both saturate at 0xFFFFFFFF and never wrap.
- Address arithmetic:
  - Line base + counter never carries out of the line, since the base has zero offset bits.
  - addr_i near 2^ADDR_W-1 is valid; there is no wrap beyond the line.

Test Plan:
- Cold miss: reset, req addr 0x10. Expect mem_addr_o 0x10, 0x11, 0x12, 0x13 in order, each held until gnt. Memory returns 0xA0..0xA3. Expect rvalid_o=1, rdata_o=0xA0 one cycle after the 4th rvalid; miss_cnt_o=1.
- Streaming hits: after the cold miss, req 0x11, 0x12, 0x13 on consecutive cycles. Expect rvalid_o on three consecutive cycles with 0xA1, 0xA2, 0xA3; no mem_req_o; hit_cnt_o=3.
- Mid-line miss: req 0x22. Expect refill at 0x20..0x23 and a response equal to the third word returned.
- Conflict and gnt stall:
  - req 0x50 (same index 4 as 0x10, different tag) with mem_gnt_i delayed 3 cycles per word. Expect mem_addr_o stable during each stall and a refill of 0x50..0x53.
  - Then req 0x10 must miss again.
- Flush mid-refill: assert flush_i during the 2nd word of a refill. Expect the response still delivered. A repeat of the same address then misses, and prior resident lines also miss.
- Reset mid-refill: drop rst_ni during REFILL_WAIT. Expect all outputs at reset values. A stale mem_rvalid_i afterwards causes no write and no rvalid_o, and the next request misses.

Source files
------------

// File: rtl/triumph_icache.sv
// Direct-mapped, read-only instruction cache serving IF-stage fetches.
// Misses refill a whole line over a single-outstanding req/gnt/rvalid bus.
module triumph_icache #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16,
    parameter int ADDR_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              ready_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE,
        REFILL_REQ,
        REFILL_WAIT,
        RESP
    } state_e;

    state_e state_q, state_d;

    logic [31:0]          data_q [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    logic [LINE_W-1:0]    base_q;
    logic [OFF_W-1:0]     off_q;
    logic [OFF_W-1:0]     cnt_q;
    logic                 flush_pend_q;

    logic [IDX_W-1:0]       req_idx;
    logic [TAG_W-1:0]       req_tag;
    logic [OFF_W+IDX_W-1:0] req_slot;
    logic [IDX_W-1:0]       ref_idx;
    logic [TAG_W-1:0]       ref_tag;
    logic                   accept;
    logic                   hit;
    logic                   beat;
    logic                   last_word;
    logic                   refill_done;
    logic                   in_refill;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    assign req_idx     = addr_i[OFF_W+IDX_W-1:OFF_W];
    assign req_tag     = addr_i[ADDR_W-1:OFF_W+IDX_W];
    assign req_slot    = addr_i[OFF_W+IDX_W-1:0];
    assign ref_idx     = base_q[IDX_W-1:0];
    assign ref_tag     = base_q[LINE_W-1:IDX_W];

    assign ready_o     = rst_ni && (state_q == IDLE);
    assign accept      = req_i && ready_o;
    // A flush in the acceptance cycle wins: the lookup is forced to miss.
    assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !flush_i;
    assign beat        = (state_q == REFILL_WAIT) && mem_rvalid_i;
    assign last_word   = &cnt_q;
    assign refill_done = beat && last_word;
    assign in_refill   = (state_q == REFILL_REQ) || (state_q == REFILL_WAIT);

    assign mem_req_o   = (state_q == REFILL_REQ);
    assign mem_addr_o  = mem_req_o ? {base_q, cnt_q} : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (accept && !hit) state_d = REFILL_REQ;
            REFILL_REQ:  if (mem_gnt_i) state_d = REFILL_WAIT;
            REFILL_WAIT: if (mem_rvalid_i) state_d = last_word ? RESP : REFILL_REQ;
            RESP:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // Control state: FSM, valid bits, response register, counters
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            rvalid_o     <= 1'b0;
            rdata_o      <= '0;
            hit_cnt_o    <= '0;
            miss_cnt_o   <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_o <= 1'b0;

            if (accept) begin
                if (hit) begin
                    rvalid_o  <= 1'b1;
                    rdata_o   <= data_q[req_slot];
                    hit_cnt_o <= sat_inc(hit_cnt_o);
                end else begin
                    miss_cnt_o <= sat_inc(miss_cnt_o);
                end
            end

            // The final beat is not yet in the array, so bypass it.
            if (refill_done) begin
                rvalid_o <= 1'b1;
                rdata_o  <= (off_q == cnt_q) ? mem_rdata_i : data_q[{ref_idx, off_q}];
            end

            if (flush_i && !in_refill) begin
                valid_q <= '0;
            end else if (refill_done) begin
                if (flush_pend_q || flush_i) valid_q <= '0;
                else                         valid_q[ref_idx] <= 1'b1;
            end

            if (flush_i && in_refill)  flush_pend_q <= 1'b1;
            else if (state_d == IDLE)  flush_pend_q <= 1'b0;
        end
    end

    // Datapath storage: line buffer, tags, latched miss request
    always_ff @(posedge clk_i) begin
        if (accept && !hit) begin
            base_q <= addr_i[ADDR_W-1:OFF_W];
            off_q  <= addr_i[OFF_W-1:0];
            cnt_q  <= '0;
        end
        if (beat) begin
            data_q[{ref_idx, cnt_q}] <= mem_rdata_i;
            if (last_word) tag_q[ref_idx] <= ref_tag;
            else           cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
